// File: rtl/pcm_dac_i2s_master.sv
// pcm_dac_i2s_master: I2S master DAC transmitter; define PCM_DAC_UNDERRUN_MUTE_EN to mute instead of repeat on underrun
module pcm_dac_i2s_master #(
  parameter int BCK_HALF  = 4,
  parameter int SLOT_BITS = 32,
  parameter int DATA_BITS = 24
) (
  input  logic                 clk_40MHz,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] left_in,
  input  logic [DATA_BITS-1:0] right_in,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic                 scki,
  output logic                 bck,
  output logic                 lrck,
  output logic                 dout,
  output logic                 frame_start,
  output logic                 underrun
);
  localparam int FRAME = 2 * SLOT_BITS;
  localparam int FW    = $clog2(FRAME);
  localparam int DW    = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
  logic [DW-1:0]          r_div;
  logic [FW-1:0]          r_fbit;
  logic                   r_full;
  logic [2*DATA_BITS-1:0] r_hold, r_shift, r_last;
  logic                   w_tick, w_fall, w_load, w_accept, w_right, w_on, w_bit;
  logic [FW-1:0]          w_nbit, w_slot, w_idx;
  logic [DATA_BITS-1:0]   w_ch;
  assign sample_ready = ~r_full;
  always_comb begin
    w_tick   = r_div == DW'(BCK_HALF - 1);
    w_fall   = w_tick && bck;
    w_nbit   = (r_fbit == FW'(FRAME - 1)) ? '0 : r_fbit + 1'b1;
    w_right  = w_nbit >= FW'(SLOT_BITS);
    w_slot   = w_right ? w_nbit - FW'(SLOT_BITS) : w_nbit;
    w_on     = (w_slot != '0) && (w_slot <= FW'(DATA_BITS));
    w_idx    = FW'(DATA_BITS) - w_slot;
    w_ch     = w_right ? r_shift[DATA_BITS-1:0] : r_shift[2*DATA_BITS-1:DATA_BITS];
    w_bit    = |(w_ch & (DATA_BITS'(1) << w_idx));
    w_load   = w_fall && (w_nbit == '0);
    w_accept = sample_valid && !r_full;
  end
  always_ff @(posedge clk_40MHz) begin
    if (reset) begin
      scki        <= 1'b0;
      bck         <= 1'b0;
      lrck        <= 1'b1;
      dout        <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      r_div       <= '0;
      r_fbit      <= FW'(FRAME - 1);
      r_full      <= 1'b0;
      r_hold      <= '0;
      r_shift     <= '0;
      r_last      <= '0;
    end else begin
      scki        <= ~scki;
      r_div       <= w_tick ? '0 : r_div + 1'b1;
      bck         <= w_tick ? ~bck : bck;
      frame_start <= w_load;
      underrun    <= w_load && !r_full;
      if (w_fall) begin
        r_fbit <= w_nbit;
        lrck   <= w_right;
        dout   <= w_on && w_bit;
      end
      // an underrun load takes nothing from holding, so the same edge may still accept
`ifdef PCM_DAC_UNDERRUN_MUTE_EN
      if (w_load) r_shift <= r_full ? r_hold : '0;
`else
      if (w_load) r_shift <= r_full ? r_hold : r_last;
`endif
      if (w_load && r_full) begin
        r_last <= r_hold;
        r_hold <= '0;
        r_full <= 1'b0;
      end else if (w_accept) begin
        r_hold <= {left_in, right_in};
        r_full <= 1'b1;
      end
    end
  end
endmodule

// File: doc/pcm_dac_i2s_master.md
Name: pcm_dac_i2s_master

Overview:
- I2S master transmitter, clocked from clk_40MHz: the output-side counterpart of the PCM1802 capture path, feeding a PCM-series stereo DAC.
- Generates SCKI (20 MHz), BCK (5 MHz) and LRCK (78.125 kHz) as registered outputs; no derived clock drives any flop.
- Serialises 24-bit left/right samples, MSB first, I2S format.
- Upstream sample source hands over one stereo frame per LRCK period through a one-deep valid/ready holding register.

Parameters:
- BCK_HALF, 4: clk_40MHz cycles per BCK half-period (BCK = 40 MHz / (2*BCK_HALF)).
- SLOT_BITS, 32: BCK cycles per channel slot (frame = 2*SLOT_BITS).
- DATA_BITS, 24: sample width; must satisfy DATA_BITS < SLOT_BITS.

Ports:
- clk_40MHz  input  1  system clock; sole clock.
- reset  input  1  synchronous, active-high reset.
- left_in  input  DATA_BITS  left sample, two's complement.
- right_in  input  DATA_BITS  right sample, two's complement.
- sample_valid  input  1  left_in/right_in valid.
- sample_ready  output  1  holding register empty; transfer when valid&&ready.
- scki  output  1  DAC system clock, 20 MHz.
- bck  output  1  bit clock.
- lrck  output  1  word clock; 0 = left slot.
- dout  output  1  serial data to DAC.
- frame_start  output  1  one-cycle pulse when a frame is loaded into the shifter.
- underrun  output  1  one-cycle pulse when a frame load finds the holding register empty.

Behaviour:
- Reset, sampled on clk_40MHz rising edge:
  - scki=0, bck=0, lrck=1, dout=0.
  - frame_start=0, underrun=0.
  - div=0, frame_bit=2*SLOT_BITS-1.
  - Holding register empty (sample_ready=1). Shifter and last-frame registers cleared to 0.
- Reset mid-operation: same values on the next edge. An in-flight frame is discarded and the holding contents are lost.
- scki toggles every clk cycle.
- div counts 0..BCK_HALF-1, then wraps. At div==BCK_HALF-1, bck toggles.
- Falling-edge event F: div==BCK_HALF-1 && bck==1. All serial-side updates occur on F only, so lrck and dout change on BCK falling edges and are stable at BCK rising edges.
- On F:
  - frame_bit increments, wrapping 2*SLOT_BITS-1 -> 0.
  - lrck <= (new frame_bit >= SLOT_BITS).
  - dout <= bit for new frame_bit.
- Data mapping, with s = new frame_bit mod SLOT_BITS:
  - s in 1..DATA_BITS: dout = channel bit [DATA_BITS-s]; MSB at s=1, one BCK after the LRCK edge (I2S).
  - s = 0 or s > DATA_BITS: dout = 0.
- First F after reset occurs at clk edge 8 (default params). At that edge frame_bit becomes 0 and lrck falls.
- Frame load, on F where new frame_bit==0:
  - If holding full: shifter <= holding; holding cleared; frame_start=1 for one cycle.
  - If holding empty: underrun=1 and frame_start=1 for one cycle; shifter loaded per optional feature.
  - The dout value driven at frame_bit 0 is 0, so the load never affects the bit being driven.
- Handshake:
  - sample_ready = holding empty, registered.
  - Accept on valid&&ready: holding <= {left_in,right_in}; full; ready deasserts the following cycle.
  - Load and accept cannot coincide: ready=0 whenever a load takes data.
  - valid held with ready=0: no effect.
  - At most one frame is buffered. Upstream may refill as soon as frame_start pulses.
- Default timing: bck period 8 clk; lrck period 512 clk; frame = 64 BCK.

Optional Feature:
- Macro: PCM_DAC_UNDERRUN_MUTE_EN.
- Defined: on underrun, the shifter loads 0 for both channels (mute).
- Undefined: on underrun, the shifter reloads the last successfully loaded frame. This is 0 if none has been loaded since reset.
- underrun pulse behaviour is identical in both builds.

Test Plan:
- Reset checks:
  - Hold reset 5 cycles, release -> scki=0, bck=0, lrck=1, dout=0, sample_ready=1.
  - First bck rise at edge 4; first fall at edge 8, with lrck=0 and frame_start=1 at edge 8.
- Clock periods: run free 2048 cycles -> scki period 2, bck period 8, lrck period 512 clk, lrck edges coincide with bck falls.
- Serial data: accept left=0xA5A5A5, right=0x123456 before first load -> stream matches.
  - Left slot bits 1..24 = A5A5A5 MSB-first; bits 0 and 25..31 zero.
  - Right slot same with 0x123456.
  - Bench samples dout on bck rising edges.
- Backpressure: present two frames back-to-back.
  - Second waits with ready=0 until the frame_start of the next frame.
  - Second frame is output exactly one frame after the first; no data lost or duplicated.
- Underrun: load 0x7FFFFF/0x800000, then withhold valid.
  - underrun pulses once per frame.
  - Next frame carries 0/0 with PCM_DAC_UNDERRUN_MUTE_EN, 0x7FFFFF/0x800000 without.
- Reset mid-frame: assert reset at frame_bit 10 with holding full.
  - Outputs return to reset values; sample_ready=1.
  - The following frame is an underrun, not stale holding data.
